// File: rtl/apb_slave_regs_if.sv
// APB completer-side bus bundle for apb_slave_regs.
//   psel/penable/paddr/pwrite/pwdata : driven by the APB requester (master modport)
//   prdata/pready/pslverr            : driven by the completer (slave modport)
//   pstrb                            : byte-lane write strobes, present only when
//                                      APB_SLV_PSTRB_EN is defined
interface apb_slave_regs_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    psel;
    logic                    penable;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
`else
    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
`endif
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer register bank with programmable wait states.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write.
// Illegal accesses (misaligned, out of range, write to ID) answer with pslverr.
// Optional feature macro: APB_SLV_PSTRB_EN adds per-byte write strobes (apb.pstrb).
// Ports:
//   hclk     : clock
//   hreset_n : asynchronous active-low reset
//   apb      : APB completer bus (slave modport of apb_slave_regs_if)
//   reg_out  : flat register contents, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
module apb_slave_regs #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 12,
    parameter int unsigned           NUM_REGS    = 8,
    parameter int unsigned           WAIT_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic                           hclk,
    input  logic                           hreset_n,
    apb_slave_regs_if.slave                apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [StrbW-1:0]      wr_strb;
    logic                  commit;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0] rf     [NUM_REGS];

    logic [IdxW-1:0]       idx_d, idx_q;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  hit, err;

`ifdef APB_SLV_PSTRB_EN
    logic [StrbW-1:0] strb_q, strb_d;
    assign wr_strb = strb_q;
`else
    assign wr_strb = '1;
`endif

    // Register file view: slot 0 is the constant ID, the rest are flops.
    always_comb begin
        rf[0] = ID_VALUE;
        for (int k = 1; k < NUM_REGS; k++) rf[k] = regs_q[k];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = rf[g];
    end

    // Decode works on the next-cycle address so that a zero-wait transfer can
    // load prdata/pslverr straight from the setup phase.
    assign idx_d = addr_d[ADDR_WIDTH-1:2];
    assign idx_q = addr_q[ADDR_WIDTH-1:2];

    always_comb begin
        rd_val = '0;
        hit    = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_d == IdxW'(k)) begin
                rd_val = rf[k];
                hit    = 1'b1;
            end
        end
        err = (addr_d[1:0] != 2'b00) || !hit || (write_d && idx_d == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
`ifdef APB_SLV_PSTRB_EN
        strb_d  = strb_q;
`endif
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // penable without a preceding setup phase is ignored.
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
`ifdef APB_SLV_PSTRB_EN
                    strb_d  = apb.pstrb;
`endif
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? StReady : StWait;
                end
            end
            StWait: begin
                if (!apb.psel) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = StReady;
                end
            end
            StReady: begin
                commit  = apb.psel && apb.penable && write_q && !pslverr_q;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        pready_d  = (state_d == StReady);
        pslverr_d = pready_d && err;
        prdata_d  = (pready_d && !err && !write_d) ? rd_val : '0;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= strb_d;
`endif
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else if (commit) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (idx_q == IdxW'(k)) begin
                    for (int b = 0; b < StrbW; b++) begin
                        if (wr_strb[b]) regs_q[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: three instances (0, 1 and 3 wait states)
// share one set of bus drivers; 'target' picks which one is selected.
module tb_apb_slave_regs;
    localparam logic [31:0] Id = 32'hA2B0_0001;

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        psel_r = 1'b0;
    logic        penable_r = 1'b0;
    logic        pwrite_r = 1'b0;
    logic [11:0] paddr_r = '0;
    logic [31:0] pwdata_r = '0;
    int          target = 1;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb_r = 4'hF;
`endif

    logic [255:0] reg_out0, reg_out1, reg_out3;
    logic [31:0]  prdata_m;
    logic         pready_m, pslverr_m;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] model [8];

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    apb_slave_regs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();
    apb_slave_regs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel = psel_r && (target == 0);
    assign bus1.psel = psel_r && (target == 1);
    assign bus3.psel = psel_r && (target == 3);
    assign bus0.penable = penable_r && (target == 0);
    assign bus1.penable = penable_r && (target == 1);
    assign bus3.penable = penable_r && (target == 3);
    assign bus0.paddr = paddr_r;
    assign bus1.paddr = paddr_r;
    assign bus3.paddr = paddr_r;
    assign bus0.pwrite = pwrite_r;
    assign bus1.pwrite = pwrite_r;
    assign bus3.pwrite = pwrite_r;
    assign bus0.pwdata = pwdata_r;
    assign bus1.pwdata = pwdata_r;
    assign bus3.pwdata = pwdata_r;
`ifdef APB_SLV_PSTRB_EN
    assign bus0.pstrb = pstrb_r;
    assign bus1.pstrb = pstrb_r;
    assign bus3.pstrb = pstrb_r;
`endif

    apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
        .hclk(hclk), .hreset_n(hreset_n), .apb(bus0), .reg_out(reg_out0));
    apb_slave_regs #(.WAIT_CYCLES(1)) dut1 (
        .hclk(hclk), .hreset_n(hreset_n), .apb(bus1), .reg_out(reg_out1));
    apb_slave_regs #(.WAIT_CYCLES(3)) dut3 (
        .hclk(hclk), .hreset_n(hreset_n), .apb(bus3), .reg_out(reg_out3));

    always_comb begin
        prdata_m  = bus1.prdata;
        pready_m  = bus1.pready;
        pslverr_m = bus1.pslverr;
        if (target == 0) begin
            prdata_m  = bus0.prdata;
            pready_m  = bus0.pready;
            pslverr_m = bus0.pslverr;
        end else if (target == 3) begin
            prdata_m  = bus3.prdata;
            pready_m  = bus3.pready;
            pslverr_m = bus3.pslverr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [255:0] act,
                            input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_model();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = model[k];
        return r;
    endfunction

    // Setup then access phase; returns once pready is sampled high, leaving the
    // bus in its access phase so the caller may idle or start the next setup.
    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int t_setup);
        logic got;
        @(posedge hclk);
        #1;
        t_setup   = cyc;
        psel_r    = 1'b1;
        penable_r = 1'b0;
        paddr_r   = a;
        pwrite_r  = w;
        pwdata_r  = d;
        @(posedge hclk);
        #1;
        penable_r = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            lat++;
            @(negedge hclk);
            if (pready_m) got = 1'b1;
            else begin
                @(posedge hclk);
                #1;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pready_timeout: got no pready, expected pready within 20 cycles");
        end
        rdata = prdata_m;
        err   = pslverr_m;
    endtask

    task automatic idle();
        @(posedge hclk);
        #1;
        psel_r    = 1'b0;
        penable_r = 1'b0;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt, ts, t0;

        vecs[0]  = '{12'h000, 1'b0, 32'h0,         Id,            1'b0};
        vecs[1]  = '{12'h004, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2]  = '{12'h004, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{12'h000, 1'b1, 32'h1234_5678, 32'h0,         1'b1};
        vecs[4]  = '{12'h000, 1'b0, 32'h0,         Id,            1'b0};
        vecs[5]  = '{12'h020, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{12'h006, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b1};
        vecs[7]  = '{12'h004, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{12'h01C, 1'b1, 32'h0F0F_0F0F, 32'h0,         1'b0};
        vecs[9]  = '{12'h01C, 1'b0, 32'h0,         32'h0F0F_0F0F, 1'b0};
        vecs[10] = '{12'hFFC, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{12'h002, 1'b0, 32'h0,         32'h0,         1'b1};

        model[0] = Id;
        for (int k = 1; k < 8; k++) model[k] = 32'h0;

        // Reset values
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_pready", 32'(pready_m), 32'd0);
        chk("rst_pslverr", 32'(pslverr_m), 32'd0);
        chk("rst_prdata", prdata_m, 32'd0);
        chk_wide("rst_reg_out1", reg_out1, pack_model());
        chk_wide("rst_reg_out0", reg_out0, pack_model());
        hreset_n = 1'b1;

        // Table-driven transfers on the one-wait-state instance
        target = 1;
        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, er, lt, ts);
            idle();
            chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lt), 32'd2);
            if (!vecs[i].wr) chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr[4:2]] = vecs[i].wdata;
            chk_wide($sformatf("vec%0d_reg_out", i), reg_out1, pack_model());
        end

        // Zero wait states: back-to-back writes, 4 cycles total
        target = 0;
        xfer(12'h008, 1'b1, 32'h1111_1111, rd, er, lt, t0);
        chk("b2b_lat_a", 32'(lt), 32'd1);
        xfer(12'h00C, 1'b1, 32'h2222_2222, rd, er, lt, ts);
        chk("b2b_lat_b", 32'(lt), 32'd1);
        chk("b2b_setup_gap", 32'(ts - t0), 32'd2);
        idle();
        chk("b2b_total_cycles", 32'(cyc - t0), 32'd4);
        chk("b2b_reg2", reg_out0[95:64], 32'h1111_1111);
        chk("b2b_reg3", reg_out0[127:96], 32'h2222_2222);

        // Three wait states: abort by dropping psel in the 2nd access cycle
        target = 3;
        @(posedge hclk);
        #1;
        psel_r = 1'b1; penable_r = 1'b0; paddr_r = 12'h010; pwrite_r = 1'b1;
        pwdata_r = 32'h55;
        @(posedge hclk);
        #1;
        penable_r = 1'b1;
        @(negedge hclk);
        chk("abort_pready_acc1", 32'(pready_m), 32'd0);
        @(posedge hclk);
        #1;
        psel_r = 1'b0; penable_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            chk($sformatf("abort_pready_%0d", i), 32'(pready_m), 32'd0);
        end
        chk("abort_reg4", reg_out3[159:128], 32'h0);
        xfer(12'h010, 1'b0, 32'h0, rd, er, lt, ts);
        idle();
        chk("abort_read_prdata", rd, 32'h0);
        chk("abort_read_pslverr", 32'(er), 32'd0);
        chk("abort_read_latency", 32'(lt), 32'd4);

`ifdef APB_SLV_PSTRB_EN
        // Byte-lane strobes
        target = 1;
        pstrb_r = 4'hF;
        xfer(12'h008, 1'b1, 32'h1122_3344, rd, er, lt, ts);
        idle();
        pstrb_r = 4'b0101;
        xfer(12'h008, 1'b1, 32'hAABB_CCDD, rd, er, lt, ts);
        idle();
        chk("strb_merge", reg_out1[95:64], 32'h11BB_33DD);
        pstrb_r = 4'b0000;
        xfer(12'h008, 1'b1, 32'hFFFF_FFFF, rd, er, lt, ts);
        idle();
        chk("strb_zero_err", 32'(er), 32'd0);
        chk("strb_zero_keep", reg_out1[95:64], 32'h11BB_33DD);
        xfer(12'h008, 1'b0, 32'h0, rd, er, lt, ts);
        idle();
        chk("strb_read", rd, 32'h11BB_33DD);
        pstrb_r = 4'hF;
`endif

        // Reset in READY of a write: pready drops at once, write is lost
        target = 1;
        xfer(12'h00C, 1'b1, 32'hAAAA_5555, rd, er, lt, ts);
        chk("midrst_pready_before", 32'(pready_m), 32'd1);
        #2;
        hreset_n = 1'b0;
        #1;
        chk("midrst_pready_async", 32'(pready_m), 32'd0);
        chk("midrst_reg1_cleared", reg_out1[63:32], 32'h0);
        @(posedge hclk);
        #1;
        chk("midrst_reg3_lost", reg_out1[127:96], 32'h0);
        psel_r = 1'b0; penable_r = 1'b0;
        hreset_n = 1'b1;
        xfer(12'h000, 1'b0, 32'h0, rd, er, lt, ts);
        idle();
        chk("postrst_read_id", rd, Id);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
APB completer (slave) register bank that sits on one psel_x/prdata_x/pready_x/pslverr_x port of the AHB-to-APB bridge. It decodes the local address window and responds to APB setup/access phases. It inserts a parameterised number of wait states and signals errors for illegal accesses. It exposes its read/write registers as a flat bus for downstream logic.

Parameters:
DATA_WIDTH, 32, APB data width; equals `APB_DATA_WIDTH.
ADDR_WIDTH, 12, local address bits decoded (4 KB window).
NUM_REGS, 8, number of 32-bit word registers; legal range 2..64.
WAIT_CYCLES, 1, wait states inserted before pready; legal range 0..15.
ID_VALUE, 32'hA2B0_0001, read-only contents of register 0.

Ports:
hclk  input  1  system clock
hreset_n  input  1  asynchronous active-low reset
psel  input  1  APB select for this completer
penable  input  1  APB enable (access phase)
paddr  input  ADDR_WIDTH  APB address, low bits only
pwrite  input  1  1 = write, 0 = read
pwdata  input  DATA_WIDTH  APB write data
prdata  output  DATA_WIDTH  APB read data
pready  output  1  transfer complete
pslverr  output  1  transfer error, valid only while pready=1
reg_out  output  NUM_REGS*DATA_WIDTH  flat register contents; reg k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clock and reset: one clock, hclk. hreset_n is asynchronous and active-low.
- Reset values: state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0, regs 1..NUM_REGS-1 = 0. Register 0 is the constant ID_VALUE.
- All outputs are registered. reg_out reflects the register flops directly.
- States:
  - IDLE: psel=1 and penable=0 (setup phase) latches paddr, pwrite and pwdata, and loads cnt=WAIT_CYCLES. Next state is READY if WAIT_CYCLES=0, else WAIT. Any other input stays in IDLE.
  - WAIT: cnt decrements each cycle. At cnt=1 the next state is READY. If psel=0, abort to IDLE with no write.
  - READY: pready=1. prdata and pslverr are valid. A write commits on the clock edge ending this cycle, when psel=1, penable=1 and pready=1. Next state is always IDLE. If psel=0 in READY, abort to IDLE with no write.
- Latency: the access phase lasts exactly WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, pready=1 in the first access cycle.
- Back-to-back transfers: the next setup phase may arrive in the cycle after READY. This gives a 2+WAIT_CYCLES cycle period per transfer with no bubble.
- Decode: word index = latched paddr[ADDR_WIDTH-1:2].
- Error conditions (any one sets pslverr=1 in READY):
  - paddr[1:0] != 0;
  - index >= NUM_REGS;
  - write to index 0.
- On error: the write is suppressed and prdata=0.
- Reads: prdata = register[index]. prdata is updated on entry to READY and held at 0 outside READY. pslverr and pready are 0 outside READY.
- penable=1 seen in IDLE without a preceding setup: ignored, with no response (protocol violation).
- Reset asserted mid-transfer: immediate return to IDLE with reset values. Any in-flight write is lost.

Optional Feature:
APB_SLV_PSTRB_EN
- Defined: adds input pstrb, width DATA_WIDTH/8, latched in setup. A write updates only the byte lanes whose pstrb bit is 1. A write with pstrb=0 is legal and leaves the register unchanged. Reads ignore pstrb.
- Undefined: no pstrb port. Every legal write updates all bytes.

Test Plan:
- Reset with WAIT_CYCLES=1 -> reg_out=0 except reg0=32'hA2B0_0001, pready=0, pslverr=0; read paddr 0x000 -> prdata=32'hA2B0_0001, pready=1 in the 2nd access cycle, pslverr=0.
- Write 32'hDEAD_BEEF to 0x004, then read 0x004 -> reg_out[63:32]=32'hDEAD_BEEF after the write's READY edge; read returns 32'hDEAD_BEEF, pslverr=0.
- Error cases:
  - write to 0x000 -> pslverr=1, reg0 unchanged;
  - read from 0x020 (NUM_REGS=8) -> pslverr=1, prdata=0;
  - write to 0x006 -> pslverr=1, reg1 unchanged.
- WAIT_CYCLES=0: back-to-back writes to 0x008 and 0x00C, with setup following READY directly -> each pready in the first access cycle; both registers updated; 4 cycles total.
- Abort: WAIT_CYCLES=3, write 0x55 to 0x010, drop psel in the 2nd access cycle -> no pready, reg4 unchanged, state returns to IDLE; a following read of 0x010 returns 0.
- With APB_SLV_PSTRB_EN: reg2=32'h1122_3344, write 32'hAABB_CCDD with pstrb=4'b0101 -> reg2=32'h11BB_33DD.
- Reset asserted mid-transfer: pready=0 immediately, asynchronously.
